softmax_seq: RTL and testbench
==============================

SOFTMAX_SEQ -- requirements
Module: softmax_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 16, logit buffer entries (power of two, max 16).
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_payload_function_id in 10 (op = bits[9:3]), cmd_payload_inputs_0 in 32, cmd_payload_inputs_1 in 32.
REQ-005 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_payload_outputs_0 out 32.

Function
REQ-006 SHALL decode ops as CFG=0, LOAD=1, RUN=2, READ=3; any other op responds 0 with no state change.
REQ-007 SHALL accept a command only when cmd_valid && cmd_ready; cmd_ready = state IDLE && !rsp_valid.
REQ-008 SHALL hold rsp_valid and rsp_payload_outputs_0 stable until rsp_ready; clear rsp_valid on the rsp_valid && rsp_ready edge.
REQ-009 CFG SHALL set frac_bits = inputs_0 clamped to 2..31, clear count to 0, and respond 0 one cycle later.
REQ-010 LOAD SHALL write signed inputs_1 to buf[count], increment count, and respond with the new count; when count==DEPTH it writes nothing and responds 0xFFFFFFFF.
REQ-011 RUN with count==0 SHALL respond 0 one cycle later; otherwise the FSM walks IDLE->MAX->EXP->RECIP->NORM->DONE->IDLE.
REQ-012 MAX SHALL scan buf[0..n-1], one per cycle (n cycles), and keep the signed maximum m.
REQ-013 EXP SHALL issue d_i = m - buf[i] (unsigned), exp index = min(d_i >> (frac_bits-2), 63), one per cycle.
REQ-014 EXP SHALL store e_i in ebuf[i] after the 1-cycle lookup latency, accumulate 36-bit S += e_i, and take n+1 cycles.
REQ-015 RECIP cycle 1 SHALL find p = leading-one position of S (30..35) and set idx = S[p-1:p-5].
REQ-016 RECIP cycle 2 SHALL latch r = RECIP[idx].
REQ-017 NORM SHALL compute q_i = (e_i * r) >> p with a 64-bit product, saturate to 0x7FFFFFFF, write q_i over ebuf[i], and take n+1 cycles.
REQ-018 DONE SHALL assert rsp_valid with payload n; RUN acceptance to rsp_valid rise SHALL be exactly 3n+5 cycles.
REQ-019 READ SHALL respond one cycle later with ebuf[inputs_0] if inputs_0 < count, else 0; results SHALL stay valid until the next CFG, LOAD or RUN.
REQ-020 Overflow SHALL be impossible by construction: S < 2^35 for DEPTH<=16.

Reset
REQ-021 Reset low SHALL immediately force state IDLE, rsp_valid 0, rsp_payload_outputs_0 0, count 0, frac_bits 26, S 0, and m 0; buffer contents are don't-care.
REQ-022 Reset asserted mid-RUN SHALL abort the run with no response; after release cmd_ready=1 on the first edge.

Structure
REQ-023 A shared package softmax_pkg SHALL hold the op encodings, the FSM state enum, EXP_TABLE_SIZE=64, RECIP_TABLE_SIZE=32, EXP_OFFSET_BITS=2, RECIP_OFFSET_BITS=5, and the 64-entry exp and 32-entry reciprocal table constants.
REQ-024 The lookup SHALL be a sub-module softmax_lut with a registered 1-cycle read, two ports (exp index 6b, recip index 5b), and 32-bit outputs.
REQ-025 The FSM, buffers, max, accumulator and normaliser SHALL live in softmax_seq.

Verification
REQ-026 CFG 26; LOAD 0x04000000 then 0 -> RUN responds 2 at cycle 11; READ 0 -> 0x5D1745D0; READ 1 -> 0x1111111B ((0x2F16AC6C*0x5D1745D1)>>31, exact value checked against the model).
REQ-027 CFG 26; LOAD 3 equal logits -> RUN responds 3 at cycle 14; READ 0..2 -> 0x2AAAAAAA each.
REQ-028 CFG 26; single LOAD -> RUN responds 1; READ 0 -> 0x7FFFFFFF; READ 5 -> 0.
REQ-029 CFG 26; 16 LOADs return 1..16, 17th returns 0xFFFFFFFF; RUN with 0 loads after CFG responds 0 next cycle.
REQ-030 Reset pulsed during NORM -> no rsp_valid, cmd_ready=1 after release, READ 0 -> 0.
REQ-031 rsp_ready held low 5 cycles after RUN done -> payload stable, cmd_ready=0 throughout.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared encodings, FSM states and lookup-table constants for the sequential softmax unit.
// Tables are generated at elaboration time with integer-only constant functions.
package softmax_pkg;

   localparam int EXP_TABLE_SIZE    = 64;
   localparam int RECIP_TABLE_SIZE  = 32;
   localparam int EXP_OFFSET_BITS   = 2;
   localparam int RECIP_OFFSET_BITS = 5;

   localparam logic [6:0] OP_CFG  = 7'd0;
   localparam logic [6:0] OP_LOAD = 7'd1;
   localparam logic [6:0] OP_RUN  = 7'd2;
   localparam logic [6:0] OP_READ = 7'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MAX,
      ST_EXP,
      ST_RECIP,
      ST_NORM,
      ST_DONE
   } state_e;

   typedef logic [EXP_TABLE_SIZE-1:0][31:0]   exp_table_t;
   typedef logic [RECIP_TABLE_SIZE-1:0][31:0] recip_table_t;

   // Entry k = round(exp(-k/4) * 2^31), clamped to 0x7FFFFFFF; exp(-1/4) is built
   // from its Taylor series in Q62 so that the running product keeps ample guard bits.
   function automatic exp_table_t build_exp_table();
      exp_table_t   tab;
      logic [127:0] term;
      logic [127:0] pos;
      logic [127:0] neg;
      logic [127:0] ratio;
      logic [127:0] acc;
      logic [127:0] rnd;
      pos  = 128'd1 << 62;
      neg  = '0;
      term = 128'd1 << 62;
      for (int n = 1; n <= 24; n++) begin
         term = term / 128'(4 * n);
         if (n % 2 == 1) neg = neg + term;
         else            pos = pos + term;
      end
      ratio = pos - neg;
      acc   = 128'd1 << 62;
      for (int k = 0; k < EXP_TABLE_SIZE; k++) begin
         rnd    = (acc + (128'd1 << 30)) >> 31;
         tab[k] = (rnd > 128'h7FFF_FFFF) ? 32'h7FFF_FFFF : rnd[31:0];
         acc    = (acc * ratio) >> 62;
      end
      return tab;
   endfunction

   // Entry i = round(2^36 / (33 + i)): reciprocal of the mantissa 1.idx, biased to the bucket top.
   function automatic recip_table_t build_recip_table();
      recip_table_t tab;
      logic [63:0]  den;
      for (int i = 0; i < RECIP_TABLE_SIZE; i++) begin
         den    = 64'(i) + 64'd33;
         tab[i] = 32'(((64'd1 << 36) + (den >> 1)) / den);
      end
      return tab;
   endfunction

   localparam exp_table_t   EXP_TABLE   = build_exp_table();
   localparam recip_table_t RECIP_TABLE = build_recip_table();

endpackage

// File: rtl/softmax_lut.sv
// Dual lookup ROM (exp and reciprocal) with one cycle of registered read latency.
module softmax_lut
   import softmax_pkg::*;
(
   input  logic                         clk,
   input  logic [5:0]                   exp_idx,
   input  logic [RECIP_OFFSET_BITS-1:0] recip_idx,
   output logic [31:0]                  exp_val,
   output logic [31:0]                  recip_val
);

   logic [31:0] exp_val_q;
   logic [31:0] recip_val_q;

   always_ff @(posedge clk) begin
      exp_val_q   <= EXP_TABLE[exp_idx];
      recip_val_q <= RECIP_TABLE[recip_idx];
   end

   assign exp_val   = exp_val_q;
   assign recip_val = recip_val_q;

endmodule

// File: rtl/softmax_seq.sv
// Sequential fixed-point softmax over up to DEPTH logits behind a cmd/rsp handshake.
// Pipeline: max scan, exp lookup + sum, reciprocal lookup, normalise in place.
module softmax_seq
   import softmax_pkg::*;
#(
   parameter int DEPTH = 16
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_payload_function_id,
   input  logic [31:0] cmd_payload_inputs_0,
   input  logic [31:0] cmd_payload_inputs_1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_payload_outputs_0
);

   localparam int            AW      = $clog2(DEPTH);
   localparam int            CW      = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   state_e             state_q, state_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_data_q, rsp_data_d;
   logic [CW-1:0]      count_q, count_d;
   logic [CW-1:0]      step_q, step_d;
   logic [4:0]         frac_q, frac_d;
   logic [35:0]        sum_q, sum_d;
   logic signed [31:0] max_q, max_d;
   logic [5:0]         p_q, p_d;
   logic [31:0]        r_q, r_d;
   logic [31:0]        e_rd_q, e_rd_d;

   logic signed [31:0] logit_mem [DEPTH];
   logic [31:0]        exp_mem   [DEPTH];
   logic               logit_we, exp_we;
   logic [AW-1:0]      logit_wa, exp_wa;
   logic [31:0]        logit_wd, exp_wd;

   logic [6:0]                   op;
   logic                         cmd_fire, rsp_fire;
   logic [AW-1:0]                step_idx, prev_idx;
   logic signed [31:0]           logit_cur;
   logic [31:0]                  diff, diff_shift;
   logic [5:0]                   exp_idx_calc;
   logic [5:0]                   p_calc;
   logic [RECIP_OFFSET_BITS-1:0] idx_calc;
   logic [63:0]                  product, scaled;
   logic [31:0]                  q_sat;
   logic [31:0]                  lut_exp_val, lut_recip_val;
   logic [2:0]                   unused_fid_bits;

   assign op              = cmd_payload_function_id[9:3];
   assign unused_fid_bits = cmd_payload_function_id[2:0];
   assign cmd_ready       = (state_q == ST_IDLE) && !rsp_valid_q;
   assign cmd_fire        = cmd_valid && cmd_ready;
   assign rsp_fire        = rsp_valid_q && rsp_ready;

   assign step_idx  = step_q[AW-1:0];
   assign prev_idx  = AW'(step_q - CW'(1));
   assign logit_cur = logit_mem[step_idx];

   // Distance from the maximum is non-negative, so it is treated as unsigned.
   assign diff         = 32'(max_q - logit_cur);
   assign diff_shift   = diff >> (frac_q - 5'(EXP_OFFSET_BITS));
   assign exp_idx_calc = (diff_shift > 32'd63) ? 6'd63 : diff_shift[5:0];

   // The sum always contains the max term (~2^31), so its top bit is at 30 or above.
   always_comb begin
      p_calc = 6'd30;
      for (int b = 31; b <= 35; b++) begin
         if (sum_q[b]) p_calc = 6'(b);
      end
      idx_calc = RECIP_OFFSET_BITS'(sum_q >> (p_calc - 6'(RECIP_OFFSET_BITS)));
   end

   assign product = 64'(e_rd_q) * 64'(r_q);
   assign scaled  = product >> p_q;
   assign q_sat   = (scaled > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : scaled[31:0];

   softmax_lut u_lut (
      .clk       (clk),
      .exp_idx   (exp_idx_calc),
      .recip_idx (idx_calc),
      .exp_val   (lut_exp_val),
      .recip_val (lut_recip_val)
   );

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      count_d     = count_q;
      step_d      = step_q;
      frac_d      = frac_q;
      sum_d       = sum_q;
      max_d       = max_q;
      p_d         = p_q;
      r_d         = r_q;
      e_rd_d      = e_rd_q;
      logit_we    = 1'b0;
      logit_wa    = '0;
      logit_wd    = cmd_payload_inputs_1;
      exp_we      = 1'b0;
      exp_wa      = prev_idx;
      exp_wd      = lut_exp_val;

      case (state_q)
         ST_IDLE: begin
            if (rsp_fire) rsp_valid_d = 1'b0;
            if (cmd_fire) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               case (op)
                  OP_CFG: begin
                     if (cmd_payload_inputs_0 < 32'd2)       frac_d = 5'd2;
                     else if (cmd_payload_inputs_0 > 32'd31) frac_d = 5'd31;
                     else                                    frac_d = cmd_payload_inputs_0[4:0];
                     count_d = '0;
                  end
                  OP_LOAD: begin
                     if (count_q == DEPTH_C) begin
                        rsp_data_d = 32'hFFFF_FFFF;
                     end else begin
                        logit_we   = 1'b1;
                        logit_wa   = count_q[AW-1:0];
                        count_d    = count_q + CW'(1);
                        rsp_data_d = 32'(count_q + CW'(1));
                     end
                  end
                  OP_RUN: begin
                     if (count_q != '0) begin
                        rsp_valid_d = 1'b0;
                        state_d     = ST_MAX;
                        step_d      = '0;
                        sum_d       = '0;
                     end
                  end
                  OP_READ: begin
                     if (cmd_payload_inputs_0 < 32'(count_q))
                        rsp_data_d = exp_mem[cmd_payload_inputs_0[AW-1:0]];
                  end
                  default: ;
               endcase
            end
         end

         ST_MAX: begin
            if (step_q == '0 || logit_cur > max_q) max_d = logit_cur;
            if (step_q == count_q - CW'(1)) begin
               step_d  = '0;
               state_d = ST_EXP;
            end else begin
               step_d = step_q + CW'(1);
            end
         end

         // Index issued in step i returns from the LUT in step i+1.
         ST_EXP: begin
            if (step_q != '0) begin
               exp_we = 1'b1;
               sum_d  = sum_q + 36'(lut_exp_val);
            end
            if (step_q == count_q) begin
               step_d  = '0;
               state_d = ST_RECIP;
            end else begin
               step_d = step_q + CW'(1);
            end
         end

         ST_RECIP: begin
            if (step_q == '0) begin
               p_d    = p_calc;
               step_d = CW'(1);
            end else begin
               r_d     = lut_recip_val;
               step_d  = '0;
               state_d = ST_NORM;
            end
         end

         // Read e_i in step i, write its normalised value back in step i+1.
         ST_NORM: begin
            if (step_q != count_q) e_rd_d = exp_mem[step_idx];
            if (step_q != '0) begin
               exp_we = 1'b1;
               exp_wd = q_sat;
            end
            if (step_q == count_q) begin
               step_d      = '0;
               state_d     = ST_DONE;
               rsp_valid_d = 1'b1;
               rsp_data_d  = 32'(count_q);
            end else begin
               step_d = step_q + CW'(1);
            end
         end

         ST_DONE: begin
            if (rsp_fire) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         count_q     <= '0;
         step_q      <= '0;
         frac_q      <= 5'd26;
         sum_q       <= '0;
         max_q       <= '0;
         p_q         <= 6'd30;
         r_q         <= '0;
         e_rd_q      <= '0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         count_q     <= count_d;
         step_q      <= step_d;
         frac_q      <= frac_d;
         sum_q       <= sum_d;
         max_q       <= max_d;
         p_q         <= p_d;
         r_q         <= r_d;
         e_rd_q      <= e_rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (logit_we) logit_mem[logit_wa] <= logit_wd;
      if (exp_we)   exp_mem[exp_wa]     <= exp_wd;
   end

   assign rsp_valid             = rsp_valid_q;
   assign rsp_payload_outputs_0 = rsp_data_q;

endmodule

// File: tb/tb_softmax_seq.sv
// Self-checking bench for softmax_seq: directed vector table, handshake/reset corner
// sequences, and randomized runs checked against a real-arithmetic softmax model.
module tb_softmax_seq;

   localparam logic [6:0]  C_CFG  = 7'd0;
   localparam logic [6:0]  C_LOAD = 7'd1;
   localparam logic [6:0]  C_RUN  = 7'd2;
   localparam logic [6:0]  C_READ = 7'd3;
   localparam logic [31:0] READ1_EXP = 32'((64'h2F16AC6C * 64'h5D1745D1) >> 31);

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [9:0]  fid = '0;
   logic [31:0] in0 = '0;
   logic [31:0] in1 = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   softmax_seq #(.DEPTH(16)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .cmd_valid               (cmd_valid),
      .cmd_ready               (cmd_ready),
      .cmd_payload_function_id (fid),
      .cmd_payload_inputs_0    (in0),
      .cmd_payload_inputs_1    (in1),
      .rsp_valid               (rsp_valid),
      .rsp_ready               (rsp_ready),
      .rsp_payload_outputs_0   (rsp_data)
   );

   typedef struct {
      string       name;
      logic [6:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_rsp;
      int          exp_lat;
   } vec_t;

   vec_t   tbl[$];
   longint exp_ref   [64];
   longint recip_ref [32];
   int     model_logit [16];
   logic [31:0] model_q [16];
   int     model_n;
   int     model_frac;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic add(input string name, input logic [6:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r, input int lat);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.exp_rsp = r; v.exp_lat = lat;
      tbl.push_back(v);
   endtask

   task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
      int guard = 0;
      while (!cmd_ready && guard < 400) begin
         @(posedge clk); #1; guard++;
      end
      if (!cmd_ready) begin
         vectors++; miscompares++;
         $display("FAIL cmd_ready_timeout: ready stayed 0 for %0d cycles, expected 1", guard);
      end
      cmd_valid = 1'b1; fid = {op, 3'b000}; in0 = a; in1 = b;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic await_rsp(output logic [31:0] rsp, output int lat);
      lat = 1;
      while (!rsp_valid && lat < 400) begin
         @(posedge clk); #1; lat++;
      end
      if (!rsp_valid) begin
         vectors++; miscompares++;
         $display("FAIL rsp_timeout: no rsp_valid after %0d cycles, expected one", lat);
         rsp = '0;
      end else begin
         rsp = rsp_data;
      end
   endtask

   task automatic take_rsp();
      if (rsp_valid) begin
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         rsp_ready = 1'b0;
      end
   endtask

   task automatic do_cmd(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rsp, output int lat);
      issue(op, a, b);
      await_rsp(rsp, lat);
      take_rsp();
   endtask

   // Softmax from the arithmetic rules: max, exp bucket, sum, normalise by mantissa reciprocal.
   function automatic void model_run();
      longint m, d, k, s, idx, r, prod;
      longint e [16];
      int     p;
      m = model_logit[0];
      for (int i = 1; i < model_n; i++) if (model_logit[i] > m) m = model_logit[i];
      s = 0;
      for (int i = 0; i < model_n; i++) begin
         d = m - longint'(model_logit[i]);
         k = d >>> (model_frac - 2);
         if (k > 63) k = 63;
         e[i] = exp_ref[k];
         s += e[i];
      end
      p = 0;
      for (int b = 0; b < 36; b++) if (s[b]) p = b;
      idx = (s >>> (p - 5)) & 31;
      r   = recip_ref[idx];
      for (int i = 0; i < model_n; i++) begin
         prod = (e[i] * r) >>> p;
         model_q[i] = (prod > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : prod[31:0];
      end
   endfunction

   initial begin
      logic [31:0] rsp, held;
      int          lat, raw, mode, common, rises;
      string       nm;

      for (int k = 0; k < 64; k++) begin
         exp_ref[k] = longint'($floor((2.0 ** 31) * $exp(-real'(k) / 4.0) + 0.5));
         if (exp_ref[k] > 64'h7FFF_FFFF) exp_ref[k] = 64'h7FFF_FFFF;
      end
      for (int i = 0; i < 32; i++)
         recip_ref[i] = longint'($floor((2.0 ** 36) / (33.0 + real'(i)) + 0.5));

      // Reset state
      repeat (2) @(posedge clk);
      #3;
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_payload", rsp_data, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

      add("cfg26", C_CFG, 26, 0, 0, 1);
      add("load_one", C_LOAD, 0, 32'h0400_0000, 1, 1);
      add("load_zero", C_LOAD, 0, 0, 2, 1);
      add("run2", C_RUN, 0, 0, 2, 11);
      add("read0_pair", C_READ, 0, 0, 32'h5D17_45D0, 1);
      add("read1_pair", C_READ, 1, 0, READ1_EXP, 1);
      add("read2_oob", C_READ, 2, 0, 0, 1);
      add("bad_op5", 7'd5, 0, 32'h1234, 0, 1);
      add("read1_after_bad", C_READ, 1, 0, READ1_EXP, 1);
      add("cfg26_b", C_CFG, 26, 0, 0, 1);
      add("load_eq0", C_LOAD, 0, 32'hFFFF_0000, 1, 1);
      add("load_eq1", C_LOAD, 0, 32'hFFFF_0000, 2, 1);
      add("load_eq2", C_LOAD, 0, 32'hFFFF_0000, 3, 1);
      add("run3", C_RUN, 0, 0, 3, 14);
      add("read_eq0", C_READ, 0, 0, 32'h2AAA_AAAA, 1);
      add("read_eq1", C_READ, 1, 0, 32'h2AAA_AAAA, 1);
      add("read_eq2", C_READ, 2, 0, 32'h2AAA_AAAA, 1);
      add("bad_op127", 7'd127, 3, 3, 0, 1);
      add("read_eq0_after_bad", C_READ, 0, 0, 32'h2AAA_AAAA, 1);
      add("cfg26_c", C_CFG, 26, 0, 0, 1);
      add("load_single", C_LOAD, 0, 32'h8000_0000, 1, 1);
      add("run1", C_RUN, 0, 0, 1, 8);
      add("read0_single", C_READ, 0, 0, 32'h7FFF_FFFF, 1);
      add("read5_oob", C_READ, 5, 0, 0, 1);
      add("cfg26_d", C_CFG, 26, 0, 0, 1);
      add("run_empty", C_RUN, 0, 0, 0, 1);
      add("read0_empty", C_READ, 0, 0, 0, 1);

      foreach (tbl[i]) begin
         do_cmd(tbl[i].op, tbl[i].a, tbl[i].b, rsp, lat);
         check(tbl[i].name, rsp, tbl[i].exp_rsp);
         if (tbl[i].exp_lat >= 0) check({tbl[i].name, "_lat"}, 32'(lat), 32'(tbl[i].exp_lat));
      end

      // Fill the buffer to capacity, then overflow once, then run the full buffer.
      do_cmd(C_CFG, 26, 0, rsp, lat);
      model_frac = 26; model_n = 16;
      for (int i = 0; i < 16; i++) begin
         model_logit[i] = $signed($urandom) >>> $urandom_range(4, 28);
         do_cmd(C_LOAD, 0, model_logit[i], rsp, lat);
         check($sformatf("fill_load%0d", i + 1), rsp, 32'(i + 1));
      end
      do_cmd(C_LOAD, 0, 32'h5555, rsp, lat);
      check("load_overflow", rsp, 32'hFFFF_FFFF);
      do_cmd(C_RUN, 0, 0, rsp, lat);
      check("run16", rsp, 32'd16);
      check("run16_lat", 32'(lat), 32'd53);
      model_run();
      for (int i = 0; i < 16; i++) begin
         do_cmd(C_READ, i, 0, rsp, lat);
         check($sformatf("full_read%0d", i), rsp, model_q[i]);
      end

      // Response held under back-pressure.
      do_cmd(C_CFG, 26, 0, rsp, lat);
      do_cmd(C_LOAD, 0, 32'h0100_0000, rsp, lat);
      do_cmd(C_LOAD, 0, 32'hFF00_0000, rsp, lat);
      issue(C_RUN, 0, 0);
      await_rsp(held, lat);
      check("stall_payload", held, 32'd2);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("stall%0d_payload", c), rsp_data, held);
         check($sformatf("stall%0d_valid", c), 32'(rsp_valid), 32'd1);
         check($sformatf("stall%0d_cmd_ready", c), 32'(cmd_ready), 32'd0);
      end
      take_rsp();
      check("stall_release_valid", 32'(rsp_valid), 32'd0);

      // Reset in the middle of the normalise phase (n=4: NORM spans cycles 12..16 after accept).
      do_cmd(C_CFG, 26, 0, rsp, lat);
      for (int i = 0; i < 4; i++) do_cmd(C_LOAD, 0, 32'(i) << 24, rsp, lat);
      issue(C_RUN, 0, 0);
      repeat (13) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrun_reset_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrun_release_cmd_ready", 32'(cmd_ready), 32'd1);
      rises = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (rsp_valid) rises++;
      end
      check("midrun_no_response", 32'(rises), 32'd0);
      do_cmd(C_READ, 0, 0, rsp, lat);
      check("midrun_read0", rsp, 32'd0);

      // Randomized runs against the model.
      for (int it = 0; it < 24; it++) begin
         raw = $urandom_range(0, 40);
         model_frac = (raw < 2) ? 2 : ((raw > 31) ? 31 : raw);
         model_n = $urandom_range(1, 16);
         mode = $urandom_range(0, 2);
         common = $urandom;
         do_cmd(C_CFG, raw, 0, rsp, lat);
         check($sformatf("rnd%0d_cfg", it), rsp, 32'd0);
         for (int i = 0; i < model_n; i++) begin
            case (mode)
               0:       model_logit[i] = $urandom;
               1:       model_logit[i] = $signed($urandom) >>> $urandom_range(0, 31);
               default: model_logit[i] = (common >>> 2) + int'($urandom_range(0, 255));
            endcase
            do_cmd(C_LOAD, 0, model_logit[i], rsp, lat);
            check($sformatf("rnd%0d_load%0d", it, i), rsp, 32'(i + 1));
         end
         do_cmd(C_RUN, 0, 0, rsp, lat);
         check($sformatf("rnd%0d_run", it), rsp, 32'(model_n));
         check($sformatf("rnd%0d_run_lat", it), 32'(lat), 32'(3 * model_n + 5));
         model_run();
         for (int i = 0; i < model_n; i++) begin
            do_cmd(C_READ, i, 0, rsp, lat);
            nm = $sformatf("rnd%0d_read%0d", it, i);
            check(nm, rsp, model_q[i]);
         end
         do_cmd(C_READ, model_n + $urandom_range(0, 100), 0, rsp, lat);
         check($sformatf("rnd%0d_read_oob", it), rsp, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
